// File: rtl/ascon_round_ctrl_pkg.sv
// Shared definitions for the ASCON permutation round sequencer.
package ascon_round_ctrl_pkg;

   // Every permutation ends on round index 11, whatever its length.
   localparam logic [3:0] LAST_ROUND = 4'd11;
   localparam int MAX_ROUNDS = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FIRST = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } type_round_fsm;

   // A permutation of nb_rounds rounds starts at 12 - nb_rounds so that
   // it always finishes on LAST_ROUND.
   function automatic logic [3:0] start_round(input int nb_rounds);
      return 4'(MAX_ROUNDS - nb_rounds);
   endfunction

endpackage

// File: rtl/ascon_round_counter.sv
// 4-bit round counter: loadable, counts up to LAST_ROUND and holds there.
// A value above LAST_ROUND can only come from an upset; it is cleared.
module ascon_round_counter
   import ascon_round_ctrl_pkg::*;
(
   input  logic       clock_i,
   input  logic       resetb_i,
   input  logic       load_i,
   input  logic [3:0] load_val_i,
   input  logic       en_i,
   output logic [3:0] cnt_o
);

   logic [3:0] cnt_d;
   logic [3:0] cnt_q;

   // Next count: load wins, then recovery from illegal values, then increment.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q > LAST_ROUND) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != LAST_ROUND)) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   // Counter register with synchronous active-low reset.
   always_ff @(posedge clock_i) begin
      if (!resetb_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/ascon_round_ctrl.sv
// Round sequencer for the ASCON permutation datapath. Runs p^a or p^b on
// request, driving the add_const round index, the state-register enable and
// the input-select mux. All control outputs are registered.
//
// Handshake: start_i is a request accepted on any rising edge where the
// FSM is in IDLE or DONE; it is ignored otherwise (no queuing). done_o is a
// one-cycle acknowledge meaning the last round's result is in the state
// register. Holding start_i high through DONE restarts with no idle gap.
module ascon_round_ctrl
   import ascon_round_ctrl_pkg::*;
#(
   parameter int NB_ROUNDS_A = 12,
   parameter int NB_ROUNDS_B = 6
) (
   input  logic          clock_i,
   input  logic          resetb_i,
   input  logic          start_i,
   input  logic          mode_i,
   output logic [3:0]    round_o,
   output logic          sel_init_o,
   output logic          en_reg_state_o,
   output logic          busy_o,
   output logic          done_o,
   output type_round_fsm state_o
);

   if ((NB_ROUNDS_A < 1) || (NB_ROUNDS_A > MAX_ROUNDS)) begin : g_bad_rounds_a
      $error("ascon_round_ctrl: NB_ROUNDS_A must be in 1..12");
   end
   if ((NB_ROUNDS_B < 1) || (NB_ROUNDS_B > MAX_ROUNDS)) begin : g_bad_rounds_b
      $error("ascon_round_ctrl: NB_ROUNDS_B must be in 1..12");
   end

   localparam logic [3:0] R0_A = start_round(NB_ROUNDS_A);
   localparam logic [3:0] R0_B = start_round(NB_ROUNDS_B);

   type_round_fsm state_d;
   type_round_fsm state_q;
   logic          mode_d;
   logic          mode_q;

   logic          accept;
   logic [3:0]    load_val;
   logic [3:0]    latched_r0;
   logic [3:0]    cnt;
   logic          cnt_load;
   logic          cnt_en;
   logic [3:0]    round_next;

   logic [3:0]    round_d;
   logic [3:0]    round_q;
   logic          sel_init_d;
   logic          sel_init_q;
   logic          en_reg_state_d;
   logic          en_reg_state_q;
   logic          busy_d;
   logic          busy_q;
   logic          done_d;
   logic          done_q;

   ascon_round_counter u_counter (
      .clock_i    (clock_i),
      .resetb_i   (resetb_i),
      .load_i     (cnt_load),
      .load_val_i (load_val),
      .en_i       (cnt_en),
      .cnt_o      (cnt)
   );

   // Start acceptance and mode latch. The start round is taken from mode_i
   // directly because it is loaded on the same edge the mode is latched.
   always_comb begin
      accept     = start_i && ((state_q == IDLE) || (state_q == DONE));
      load_val   = mode_i ? R0_B : R0_A;
      latched_r0 = mode_q ? R0_B : R0_A;
      mode_d     = accept ? mode_i : mode_q;
   end

   // FSM state register.
   always_ff @(posedge clock_i) begin
      if (!resetb_i) begin
         state_q <= IDLE;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
      end
   end

   // FSM next-state logic; an out-of-range counter aborts to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start_i) state_d = FIRST;
         end
         FIRST: begin
            if (latched_r0 == LAST_ROUND) state_d = DONE;
            else                          state_d = RUN;
         end
         RUN: begin
            if (cnt == LAST_ROUND) state_d = DONE;
         end
         DONE: begin
            if (start_i) state_d = FIRST;
            else         state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (cnt > LAST_ROUND) state_d = IDLE;
   end

   // FSM output logic: outputs are computed for the state being entered so
   // that the output registers line up with the state register.
   always_comb begin
      cnt_load       = (state_d == FIRST);
      cnt_en         = (state_d == RUN);
      round_next     = '0;
      round_d        = '0;
      sel_init_d     = 1'b0;
      en_reg_state_d = 1'b0;
      busy_d         = 1'b0;
      done_d         = 1'b0;
      if (cnt_load)    round_next = load_val;
      else if (cnt_en) round_next = cnt + 4'd1;
      case (state_d)
         FIRST: begin
            round_d        = round_next;
            sel_init_d     = 1'b1;
            en_reg_state_d = 1'b1;
            busy_d         = 1'b1;
         end
         RUN: begin
            round_d        = round_next;
            en_reg_state_d = 1'b1;
            busy_d         = 1'b1;
         end
         DONE: begin
            busy_d = 1'b1;
            done_d = 1'b1;
         end
         default: ;
      endcase
   end

   // Output registers; all clear on reset so no done_o escapes an abort.
   always_ff @(posedge clock_i) begin
      if (!resetb_i) begin
         round_q        <= '0;
         sel_init_q     <= 1'b0;
         en_reg_state_q <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         round_q        <= round_d;
         sel_init_q     <= sel_init_d;
         en_reg_state_q <= en_reg_state_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
      end
   end

   assign round_o        = round_q;
   assign sel_init_o     = sel_init_q;
   assign en_reg_state_o = en_reg_state_q;
   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign state_o        = state_q;

endmodule

// File: tb/tb_ascon_round_ctrl.sv
// Bench for ascon_round_ctrl: directed sequences, per-cycle expected output
// vectors queued by the drivers and checked by a monitor on the falling edge.
// Cycle numbering: cyc counts rising edges; a start sampled on edge k shows
// FIRST outputs after edge k and done_o after edge k+N.
module tb_ascon_round_ctrl;
   import ascon_round_ctrl_pkg::*;

   localparam int W = 26;  // {cyc[15:0], round[3:0], sel, en, busy, done, state[1:0]}
   localparam int NB_A = 12;
   localparam int NB_B = 6;

   logic clk = 1'b0;
   logic resetb_i, start_i, mode_i, start1_i, mode1_i;
   logic [3:0] round_o, round1_o;
   logic sel_init_o, en_reg_state_o, busy_o, done_o;
   logic sel_init1_o, en_reg_state1_o, busy1_o, done1_o;
   type_round_fsm state_o, state1_o;

   int cyc = 0;
   int n_vec = 0;
   int n_err = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp1_q[$];

   ascon_round_ctrl #(.NB_ROUNDS_A(NB_A), .NB_ROUNDS_B(NB_B)) dut (
      .clock_i(clk), .resetb_i(resetb_i), .start_i(start_i), .mode_i(mode_i),
      .round_o(round_o), .sel_init_o(sel_init_o), .en_reg_state_o(en_reg_state_o),
      .busy_o(busy_o), .done_o(done_o), .state_o(state_o)
   );

   ascon_round_ctrl #(.NB_ROUNDS_A(12), .NB_ROUNDS_B(1)) dut1 (
      .clock_i(clk), .resetb_i(resetb_i), .start_i(start1_i), .mode_i(mode1_i),
      .round_o(round1_o), .sel_init_o(sel_init1_o), .en_reg_state_o(en_reg_state1_o),
      .busy_o(busy1_o), .done_o(done1_o), .state_o(state1_o)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard helpers ----------------
   function automatic logic [W-1:0] mk(input int c, input logic [3:0] rnd, input logic sel,
                                      input logic en, input logic busy, input logic done,
                                      input type_round_fsm st);
      return {16'(c), rnd, sel, en, busy, done, st};
   endfunction

   task automatic check(input string tag, input logic [W-1:0] e, input logic [9:0] a);
      n_vec++;
      if (a !== e[9:0]) begin
         n_err++;
         $display("FAIL %s cyc=%0d got/expected round=%0d/%0d sel=%b/%b en=%b/%b busy=%b/%b done=%b/%b state=%0d/%0d",
                  tag, cyc, a[9:6], e[9:6], a[5], e[5], a[4], e[4], a[3], e[3], a[2], e[2], a[1:0], e[1:0]);
      end
   endtask

   // Expected vectors for one permutation of nb rounds started on edge k.
   task automatic push_run(input int k, input int nb);
      for (int i = 0; i < nb; i++) begin
         exp_q.push_back(mk(k + i, 4'(12 - nb + i), (i == 0), 1'b1, 1'b1, 1'b0,
                            (i == 0) ? FIRST : RUN));
      end
      exp_q.push_back(mk(k + nb, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, DONE));
   endtask

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      logic [W-1:0] e;
      if (cyc >= 1) begin
         if ((exp_q.size() > 0) && (exp_q[0][W-1 -: 16] == 16'(cyc))) e = exp_q.pop_front();
         else e = mk(cyc, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE);
         check("dut_out", e, {round_o, sel_init_o, en_reg_state_o, busy_o, done_o, state_o});
      end
   end

   always @(negedge clk) begin
      logic [W-1:0] e;
      if (cyc >= 1) begin
         if ((exp1_q.size() > 0) && (exp1_q[0][W-1 -: 16] == 16'(cyc))) e = exp1_q.pop_front();
         else e = mk(cyc, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE);
         check("dut1_out", e, {round1_o, sel_init1_o, en_reg_state1_o, busy1_o, done1_o, state1_o});
      end
   end

   // ---------------- drivers ----------------
   task automatic to_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic start_pulse(input logic mode, output int k);
      @(negedge clk);
      k       = cyc + 1;
      start_i = 1'b1;
      mode_i  = mode;
      push_run(k, mode ? NB_B : NB_A);
      @(negedge clk);
      start_i = 1'b0;
      mode_i  = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int k;
      resetb_i = 1'b0;
      start_i  = 1'b1;   // start asserted during reset must be ignored
      mode_i   = 1'b0;
      start1_i = 1'b1;
      mode1_i  = 1'b1;
      repeat (2) @(negedge clk);
      resetb_i = 1'b1;
      start_i  = 1'b0;
      start1_i = 1'b0;
      mode1_i  = 1'b0;
      repeat (2) @(negedge clk);

      // p^a: rounds 0..11, done 12 edges after FIRST
      start_pulse(1'b0, k);
      to_cyc(k + NB_A + 3);

      // p^b: rounds 6..11
      start_pulse(1'b1, k);
      to_cyc(k + NB_B + 3);

      // Inputs wiggled during RUN are ignored; start held through DONE restarts at once.
      @(negedge clk);
      k       = cyc + 1;
      start_i = 1'b1;
      mode_i  = 1'b0;
      push_run(k, NB_A);
      while (cyc < k + 11) begin
         @(negedge clk);
         mode_i = ~mode_i;
      end
      to_cyc(k + 12);
      mode_i = 1'b1;
      push_run(k + 13, NB_B);
      to_cyc(k + 13);
      start_i = 1'b0;
      mode_i  = 1'b0;
      to_cyc(k + 13 + NB_B + 3);

      // Reset while round 5 is presented: abort with no done_o, then a clean p^a.
      start_pulse(1'b0, k);
      to_cyc(k + 5);
      resetb_i = 1'b0;
      while ((exp_q.size() > 0) && (exp_q[$][W-1 -: 16] >= 16'(k + 6))) void'(exp_q.pop_back());
      to_cyc(k + 6);
      resetb_i = 1'b1;
      start_pulse(1'b0, k);
      to_cyc(k + NB_A + 3);

      // Single-round p^b instance: FIRST on round 11, done on the next edge.
      @(negedge clk);
      k        = cyc + 1;
      start1_i = 1'b1;
      mode1_i  = 1'b1;
      exp1_q.push_back(mk(k,     4'd11, 1'b1, 1'b1, 1'b1, 1'b0, FIRST));
      exp1_q.push_back(mk(k + 1, 4'd0,  1'b0, 1'b0, 1'b1, 1'b1, DONE));
      @(negedge clk);
      start1_i = 1'b0;
      mode1_i  = 1'b0;
      to_cyc(k + 4);

      // p^b immediately followed by a separate p^a
      start_pulse(1'b1, k);
      to_cyc(k + NB_B + 1);
      start_pulse(1'b0, k);
      to_cyc(k + NB_A + 3);

      // Every queued expectation must have been consumed.
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL dut_queue_drain left=%0d required=0", exp_q.size());
      end
      n_vec++;
      if (exp1_q.size() != 0) begin
         n_err++;
         $display("FAIL dut1_queue_drain left=%0d required=0", exp1_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
